// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings and defaults for the instruction-fetch stage.
package pc_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned SELW = 2;

    // Next-PC select codes; 2'b11 is reserved and treated as PC_BR.
    localparam logic [SELW-1:0] PC_PLUS4 = 2'b00;
    localparam logic [SELW-1:0] PC_JAL   = 2'b01;
    localparam logic [SELW-1:0] PC_BR    = 2'b10;

    localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h4000_0000;
    localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_pc_next_mux.sv
// Combinational next-PC priority select with word-alignment masking.
module pc_fetch_unit_pc_next_mux
    import pc_fetch_unit_pkg::*;
(
    input  logic [SELW-1:0] i_pcsel,
    input  logic [XLEN-1:0] i_jal_target,
    input  logic [XLEN-1:0] i_br_target,
    input  logic            i_stall,
    input  logic [XLEN-1:0] i_fetch_pc,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_misaligned
);

    logic [XLEN-1:0] w_target;

    // Redirects beat stall; EX-resolved branch beats ID-resolved JAL.
    always_comb begin
        w_target     = i_br_target;
        o_next_pc    = i_fetch_pc + XLEN'(4);
        o_misaligned = 1'b0;
        if (i_pcsel[1]) begin
            w_target = i_br_target;
        end else if (i_pcsel == PC_JAL) begin
            w_target = i_jal_target;
        end
        if (i_pcsel != PC_PLUS4) begin
            o_next_pc    = w_target & 32'hFFFF_FFFC;
            o_misaligned = w_target[1];
        end else if (i_stall) begin
            o_next_pc = i_fetch_pc;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF stage: owns the PC, drives the 1-cycle IMEM, and presents instructions to ID.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  PCSel,
    input  logic [31:0] jal_target,
    input  logic [31:0] br_target,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_if,
    output logic [31:0] instr_if,
    output logic        instr_valid,
    output logic        flush_id,
    output logic        misaligned
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_misaligned;
    logic [XLEN-1:0] w_next_pc;
    logic            w_mis_strobe;

    pc_fetch_unit_pc_next_mux u_pc_next_mux (
        .i_pcsel      (PCSel),
        .i_jal_target (jal_target),
        .i_br_target  (br_target),
        .i_stall      (stall),
        .i_fetch_pc   (r_fetch_pc),
        .o_next_pc    (w_next_pc),
        .o_misaligned (w_mis_strobe)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: BOOT lasts exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_BOOT) begin
            w_state_nxt = ST_RUN;
        end
    end

    // Outputs: address select and same-cycle wrong-path kill.
    always_comb begin
        imem_addr   = RESET_PC;
        instr_valid = 1'b0;
        instr_if    = NOP_INSTR;
        flush_id    = 1'b0;
        if (r_state == ST_RUN) begin
            imem_addr = w_next_pc;
            flush_id  = PCSel[1];
            if (PCSel == PC_PLUS4) begin
                instr_valid = 1'b1;
                instr_if    = imem_rdata;
            end
        end
    end

    // fetch_pc tracks the address whose data is on imem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else begin
            r_fetch_pc <= imem_addr;
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else if ((r_state == ST_RUN) && w_mis_strobe) begin
            r_misaligned <= 1'b1;
        end
    end

    assign pc_if      = r_fetch_pc;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a synchronous-read IMEM model.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  PCSel;
    logic [31:0] jal_target;
    logic [31:0] br_target;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_if;
    logic [31:0] instr_if;
    logic        instr_valid;
    logic        flush_id;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCSel       (PCSel),
        .jal_target  (jal_target),
        .br_target   (br_target),
        .stall       (stall),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .pc_if       (pc_if),
        .instr_if    (instr_if),
        .instr_valid (instr_valid),
        .flush_id    (flush_id),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; PCSel = 2'b00; stall = 1'b0;
        jal_target = '0; br_target = '0;
        #12;
        chk1 ("rst_valid",  instr_valid, 1'b0);
        chk1 ("rst_flush",  flush_id,    1'b0);
        chk32("rst_instr",  instr_if,    NOP);
        chk32("rst_addr",   imem_addr,   RST_PC);
        chk32("rst_pc",     pc_if,       RST_PC);
        chk1 ("rst_mis",    misaligned,  1'b0);
    endtask

    // BOOT ignores redirect and stall, then sequential fetch from RESET_PC.
    task automatic test_boot(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        PCSel = 2'b10; br_target = 32'h4000_0022; stall = 1'b1;
        #1;
        chk32({tag, "_boot_addr"},  imem_addr,   RST_PC);
        chk1 ({tag, "_boot_valid"}, instr_valid, 1'b0);
        chk1 ({tag, "_boot_flush"}, flush_id,    1'b0);
        PCSel = 2'b00; stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk32({tag, "_seq_pc"},    pc_if,       RST_PC + 32'(4 * i));
            chk1 ({tag, "_seq_valid"}, instr_valid, 1'b1);
            chk32({tag, "_seq_addr"},  imem_addr,   RST_PC + 32'(4 * (i + 1)));
            chk32({tag, "_seq_instr"}, instr_if,    mem_word(RST_PC + 32'(4 * i)));
        end
        chk1({tag, "_boot_mis"}, misaligned, 1'b0);
    endtask

    // Entered with pc_if=0x4000_0008.
    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk32("stall_addr",  imem_addr,   32'h4000_0008);
            chk32("stall_pc",    pc_if,       32'h4000_0008);
            chk32("stall_instr", instr_if,    mem_word(32'h4000_0008));
            chk1 ("stall_valid", instr_valid, 1'b1);
            cyc();
        end
        stall = 1'b0;
        #1;
        chk32("unstall_addr", imem_addr, 32'h4000_000C);
        chk32("unstall_pc",   pc_if,     32'h4000_0008);
        cyc();
        chk32("post_stall_pc", pc_if, 32'h4000_000C);
    endtask

    task automatic test_jal();
        PCSel = 2'b01; jal_target = 32'h4000_0101;
        #1;
        chk1 ("jal_valid", instr_valid, 1'b0);
        chk32("jal_instr", instr_if,    NOP);
        chk1 ("jal_flush", flush_id,    1'b0);
        chk32("jal_addr",  imem_addr,   32'h4000_0100);
        cyc();
        PCSel = 2'b00;
        #1;
        chk32("jal_pc",     pc_if,       32'h4000_0100);
        chk1 ("jal_valid2", instr_valid, 1'b1);
        chk32("jal_instr2", instr_if,    mem_word(32'h4000_0100));
        chk32("jal_addr2",  imem_addr,   32'h4000_0104);
        chk1 ("jal_mis",    misaligned,  1'b0);
    endtask

    task automatic test_br_over_stall();
        cyc();
        PCSel = 2'b10; br_target = 32'h4000_0020; stall = 1'b1;
        #1;
        chk1 ("br_flush", flush_id,    1'b1);
        chk1 ("br_valid", instr_valid, 1'b0);
        chk32("br_addr",  imem_addr,   32'h4000_0020);
        cyc();
        PCSel = 2'b00; stall = 1'b0;
        #1;
        chk1 ("br_flush2", flush_id,    1'b0);
        chk32("br_pc",     pc_if,       32'h4000_0020);
        chk1 ("br_valid2", instr_valid, 1'b1);
        chk32("br_instr2", instr_if,    mem_word(32'h4000_0020));
    endtask

    // Uses reserved code 11, which must act as 10.
    task automatic test_misaligned();
        cyc();
        PCSel = 2'b11; br_target = 32'h4000_0022;
        #1;
        chk32("mis_addr",  imem_addr,  32'h4000_0020);
        chk1 ("mis_flush", flush_id,   1'b1);
        chk1 ("mis_pre",   misaligned, 1'b0);
        cyc();
        PCSel = 2'b00;
        #1;
        chk1 ("mis_set", misaligned, 1'b1);
        chk32("mis_pc",  pc_if,      32'h4000_0020);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk1("mis_sticky", misaligned, 1'b1);
        end
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk1 ("arst_valid", instr_valid, 1'b0);
        chk1 ("arst_flush", flush_id,    1'b0);
        chk32("arst_addr",  imem_addr,   RST_PC);
        chk32("arst_pc",    pc_if,       RST_PC);
        chk1 ("arst_mis",   misaligned,  1'b0);
        stall = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_boot("b1");
        test_stall();
        test_jal();
        test_br_over_stall();
        test_misaligned();
        test_async_reset();
        test_boot("b2");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
